// File: rtl/ct_hpcp_evt_cnt_pkg.sv
// Shared PMU definitions: counter geometry, event-index constants and vector types
// for the programmable hardware performance counters.
package ct_hpcp_evt_cnt_pkg;

  localparam int HPMCNT_NUM   = 42;
  localparam int HPMEVT_WIDTH = 6;
  localparam int CNT_WIDTH    = 64;

  typedef logic [HPMEVT_WIDTH-1:0] evt_idx_t;
  typedef logic [HPMCNT_NUM-1:0]   evt_vec_t;
  typedef logic [CNT_WIDTH-1:0]    cnt_t;

  localparam evt_idx_t EVT_NONE    = 6'd0;
  localparam evt_idx_t EVT_IDX_MAX = HPMEVT_WIDTH'(HPMCNT_NUM);
  localparam cnt_t     CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam cnt_t     CNT_ONES    = {CNT_WIDTH{1'b1}};

  localparam evt_idx_t EVT_L1I_ACCESS        = 6'd1;
  localparam evt_idx_t EVT_L1I_MISS          = 6'd2;
  localparam evt_idx_t EVT_IUTLB_MISS        = 6'd3;
  localparam evt_idx_t EVT_DUTLB_MISS        = 6'd4;
  localparam evt_idx_t EVT_JTLB_MISS         = 6'd5;
  localparam evt_idx_t EVT_CBR_MISPRED       = 6'd6;
  localparam evt_idx_t EVT_CBR_INST          = 6'd7;
  localparam evt_idx_t EVT_IBR_MISPRED       = 6'd8;
  localparam evt_idx_t EVT_IBR_INST          = 6'd9;
  localparam evt_idx_t EVT_LSU_SPEC_FAIL     = 6'd10;
  localparam evt_idx_t EVT_STORE_INST        = 6'd11;
  localparam evt_idx_t EVT_L1D_RD_ACCESS     = 6'd12;
  localparam evt_idx_t EVT_L1D_RD_MISS       = 6'd13;
  localparam evt_idx_t EVT_L1D_WR_ACCESS     = 6'd14;
  localparam evt_idx_t EVT_L1D_WR_MISS       = 6'd15;
  localparam evt_idx_t EVT_L2_RD_ACCESS      = 6'd16;
  localparam evt_idx_t EVT_L2_RD_MISS        = 6'd17;
  localparam evt_idx_t EVT_L2_WR_ACCESS      = 6'd18;
  localparam evt_idx_t EVT_L2_WR_MISS        = 6'd19;
  localparam evt_idx_t EVT_RF_LAUNCH_FAIL    = 6'd20;
  localparam evt_idx_t EVT_RF_LSU_OP         = 6'd21;
  localparam evt_idx_t EVT_RF_INST           = 6'd22;
  localparam evt_idx_t EVT_LSU_CROSS4K_STALL = 6'd23;
  localparam evt_idx_t EVT_LSU_OTHER_STALL   = 6'd24;
  localparam evt_idx_t EVT_LSU_SQ_DISCARD    = 6'd25;
  localparam evt_idx_t EVT_LSU_SQ_DATA_DISC  = 6'd26;
  localparam evt_idx_t EVT_IFU_BTGT_MISPRED  = 6'd27;
  localparam evt_idx_t EVT_IFU_BTGT_INST     = 6'd28;
  localparam evt_idx_t EVT_ALU_INST          = 6'd29;
  localparam evt_idx_t EVT_LDST_INST         = 6'd30;
  localparam evt_idx_t EVT_VEC_SIMD_INST     = 6'd31;
  localparam evt_idx_t EVT_CSR_INST          = 6'd32;
  localparam evt_idx_t EVT_SYNC_INST         = 6'd33;
  localparam evt_idx_t EVT_LDST_UNALIGN      = 6'd34;
  localparam evt_idx_t EVT_INT_NUM           = 6'd35;
  localparam evt_idx_t EVT_INT_OFF_CYCLE     = 6'd36;
  localparam evt_idx_t EVT_ENV_CALL          = 6'd37;
  localparam evt_idx_t EVT_LONG_JUMP         = 6'd38;
  localparam evt_idx_t EVT_FE_STALL_CYCLE    = 6'd39;
  localparam evt_idx_t EVT_BE_STALL_CYCLE    = 6'd40;
  localparam evt_idx_t EVT_SYNC_STALL_CYCLE  = 6'd41;
  localparam evt_idx_t EVT_FP_INST           = 6'd42;

  // Event idx maps to vec[idx-1]; the compare loop keeps out-of-range indices harmless.
  function automatic logic evt_pick(evt_vec_t vec, evt_idx_t idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < HPMCNT_NUM; i++) begin
      hit = hit | (vec[i] & (idx == HPMEVT_WIDTH'(i + 1)));
    end
    return hit;
  endfunction

endpackage

// File: rtl/ct_hpcp_evt_cnt_if.sv
// CSR/event bus between the PMU control logic (master) and one counter (slave).
interface ct_hpcp_evt_cnt_if;
  import ct_hpcp_evt_cnt_pkg::*;

  evt_idx_t eventx_value;
  evt_vec_t hpcp_event_vec;
  logic     hpcp_cnt_en;
  logic     cntx_inhibit;
  logic     cntx_wen;
  cnt_t     hpcp_wdata;
  logic     cntx_of_clr;
  cnt_t     cntx_value;
  logic     cntx_of;
  logic     cntx_of_int;

  modport master (
    output eventx_value, hpcp_event_vec, hpcp_cnt_en, cntx_inhibit,
           cntx_wen, hpcp_wdata, cntx_of_clr,
    input  cntx_value, cntx_of, cntx_of_int
  );

  modport slave (
    input  eventx_value, hpcp_event_vec, hpcp_cnt_en, cntx_inhibit,
           cntx_wen, hpcp_wdata, cntx_of_clr,
    output cntx_value, cntx_of, cntx_of_int
  );

endinterface

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate shared across the core.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_s;
  logic en_lat_r;

  assign clk_en_s = (global_en & (module_en | local_en)) | external_en;

  // Enable latch is transparent while the clock is low so clk_out never glitches
  always_latch begin
    if (!clk_in) begin
      en_lat_r <= clk_en_s | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & en_lat_r;

endmodule

// File: rtl/ct_hpcp_evt_cnt.sv
// One programmable performance counter: selects an event, filters it at sample
// time, counts it one cycle later, and flags wrap-around with a sticky bit and a pulse.
module ct_hpcp_evt_cnt
  import ct_hpcp_evt_cnt_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              cp0_hpcp_icg_en,
  input  logic              pad_yy_icg_scan_en,
  ct_hpcp_evt_cnt_if.slave  cnt_if
);

  logic cnt_clk_s;
  logic sel_valid_s;
  logic hit_nxt_s;
  logic hit_r;
  logic wrap_s;
  logic local_en_s;
  cnt_t cnt_value_r;
  logic cnt_of_r;
  logic cnt_of_int_r;

  // Event select and sample-time privilege/inhibit filtering
  always_comb begin
    sel_valid_s = (cnt_if.eventx_value != EVT_NONE) && (cnt_if.eventx_value <= EVT_IDX_MAX);
    hit_nxt_s   = sel_valid_s & evt_pick(cnt_if.hpcp_event_vec, cnt_if.eventx_value)
                  & cnt_if.hpcp_cnt_en & ~cnt_if.cntx_inhibit;
  end

  assign wrap_s     = hit_r & ~cnt_if.cntx_wen & (cnt_value_r == CNT_ONES);
  assign local_en_s = cnt_if.cntx_wen | hit_nxt_s | hit_r | cnt_if.cntx_of_clr | cnt_of_int_r;

  gated_clk_cell x_cnt_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (cp0_hpcp_icg_en),
    .local_en           (local_en_s),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (cnt_clk_s)
  );

  // Sample stage: a CSR write discards whatever is sampled in its own cycle
  always_ff @(posedge cnt_clk_s or posedge cpurst) begin
    if (cpurst) begin
      hit_r <= 1'b0;
    end else if (cnt_if.cntx_wen) begin
      hit_r <= 1'b0;
    end else begin
      hit_r <= hit_nxt_s;
    end
  end

  // Update stage: write beats the held hit, which is then lost
  always_ff @(posedge cnt_clk_s or posedge cpurst) begin
    if (cpurst) begin
      cnt_value_r <= {CNT_WIDTH{1'b0}};
    end else if (cnt_if.cntx_wen) begin
      cnt_value_r <= cnt_if.hpcp_wdata;
    end else if (hit_r) begin
      cnt_value_r <= cnt_value_r + CNT_ONE;
    end else begin
      cnt_value_r <= cnt_value_r;
    end
  end

  // Overflow: only an increment wrap sets the flag, and a set outranks a clear
  always_ff @(posedge cnt_clk_s or posedge cpurst) begin
    if (cpurst) begin
      cnt_of_r     <= 1'b0;
      cnt_of_int_r <= 1'b0;
    end else begin
      cnt_of_int_r <= wrap_s;
      if (wrap_s) begin
        cnt_of_r <= 1'b1;
      end else if (cnt_if.cntx_of_clr) begin
        cnt_of_r <= 1'b0;
      end else begin
        cnt_of_r <= cnt_of_r;
      end
    end
  end

  assign cnt_if.cntx_value  = cnt_value_r;
  assign cnt_if.cntx_of     = cnt_of_r;
  assign cnt_if.cntx_of_int = cnt_of_int_r;

endmodule

// File: tb/tb_ct_hpcp_evt_cnt.sv
// Directed bench for ct_hpcp_evt_cnt: hand-computed expectations checked with
// immediate assertions; inputs change #1 after the clock edge, outputs are read there too.
module tb_ct_hpcp_evt_cnt;
  import ct_hpcp_evt_cnt_pkg::*;

  logic clk;
  logic rst;
  logic icg_en;
  logic scan_en;
  int   n_cmp;
  int   n_mis;
  evt_vec_t v;

  ct_hpcp_evt_cnt_if ifc ();

  ct_hpcp_evt_cnt dut (
    .forever_cpuclk     (clk),
    .cpurst             (rst),
    .cp0_hpcp_icg_en    (icg_en),
    .pad_yy_icg_scan_en (scan_en),
    .cnt_if             (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] val, input logic of, input logic oi);
    chk({tag, ".value"}, ifc.cntx_value, val);
    chk({tag, ".of"}, {63'd0, ifc.cntx_of}, {63'd0, of});
    chk({tag, ".of_int"}, {63'd0, ifc.cntx_of_int}, {63'd0, oi});
  endtask

  task automatic pulse(input int bit_idx);
    v = '0;
    v[bit_idx] = 1'b1;
    ifc.hpcp_event_vec = v;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    icg_en = 1'b1;
    scan_en = 1'b0;
    ifc.eventx_value = EVT_NONE;
    ifc.hpcp_event_vec = '0;
    ifc.hpcp_cnt_en = 1'b1;
    ifc.cntx_inhibit = 1'b0;
    ifc.cntx_wen = 1'b0;
    ifc.hpcp_wdata = 64'd0;
    ifc.cntx_of_clr = 1'b0;

    cyc(); cyc();
    chk_all("reset", 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    icg_en = 1'b0;

    // Basic count: event 5 on bit 4 for three cycles starting at A
    cyc();
    ifc.eventx_value = EVT_JTLB_MISS;
    pulse(4);
    cyc(); chk("basic_a1", ifc.cntx_value, 64'd0);
    cyc(); chk("basic_a2", ifc.cntx_value, 64'd1);
    cyc(); chk("basic_a3", ifc.cntx_value, 64'd2);
    ifc.hpcp_event_vec = '0;
    cyc(); chk("basic_a4", ifc.cntx_value, 64'd3);
    pulse(5);
    cyc(); ifc.hpcp_event_vec = '0;
    cyc(); cyc(); chk("other_bit", ifc.cntx_value, 64'd3);

    // Zero and out-of-range selects ignore a fully active event vector
    ifc.eventx_value = EVT_NONE;
    ifc.hpcp_event_vec = '1;
    repeat (10) cyc();
    ifc.hpcp_event_vec = '0;
    cyc(); cyc(); chk("sel_zero", ifc.cntx_value, 64'd3);
    ifc.eventx_value = 6'd43;
    ifc.hpcp_event_vec = '1;
    repeat (10) cyc();
    ifc.hpcp_event_vec = '0;
    cyc(); cyc(); chk("sel_43", ifc.cntx_value, 64'd3);

    // Highest legal index maps to the top vector bit
    ifc.eventx_value = EVT_FP_INST;
    pulse(41);
    cyc(); ifc.hpcp_event_vec = '0;
    cyc(); chk("sel_42", ifc.cntx_value, 64'd4);

    // Write priority: events every cycle from M, write 0x100 at N=M+3
    ifc.eventx_value = EVT_JTLB_MISS;
    pulse(4);
    cyc();
    cyc(); chk("wr_pre1", ifc.cntx_value, 64'd5);
    cyc(); chk("wr_pre2", ifc.cntx_value, 64'd6);
    ifc.cntx_wen = 1'b1;
    ifc.hpcp_wdata = 64'h100;
    cyc(); ifc.cntx_wen = 1'b0;
    chk("wr_n1", ifc.cntx_value, 64'h100);
    cyc(); chk("wr_n2", ifc.cntx_value, 64'h100);
    cyc(); chk("wr_n3", ifc.cntx_value, 64'h101);
    cyc(); chk("wr_n4", ifc.cntx_value, 64'h102);
    ifc.hpcp_event_vec = '0;
    cyc(); cyc(); chk("wr_drain", ifc.cntx_value, 64'h103);

    // Overflow from a write of all-ones plus one event
    ifc.cntx_wen = 1'b1;
    ifc.hpcp_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(); ifc.cntx_wen = 1'b0;
    chk_all("of_wr", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    pulse(4);
    cyc(); ifc.hpcp_event_vec = '0;
    chk_all("of_pre", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    cyc(); chk_all("of_wrap", 64'd0, 1'b1, 1'b1);
    cyc(); chk_all("of_after", 64'd0, 1'b1, 1'b0);
    ifc.cntx_of_clr = 1'b1;
    cyc(); ifc.cntx_of_clr = 1'b0;
    chk_all("of_clr", 64'd0, 1'b0, 1'b0);

    // Second wrap with a coincident clear: the set must win
    ifc.cntx_wen = 1'b1;
    ifc.hpcp_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(); ifc.cntx_wen = 1'b0;
    chk_all("of2_wr", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    pulse(4);
    cyc(); ifc.hpcp_event_vec = '0;
    ifc.cntx_of_clr = 1'b1;
    cyc(); ifc.cntx_of_clr = 1'b0;
    chk_all("of2_set_wins", 64'd0, 1'b1, 1'b1);
    cyc(); chk_all("of2_after", 64'd0, 1'b1, 1'b0);

    // Filters evaluated at sample time
    ifc.cntx_inhibit = 1'b1;
    pulse(4);
    cyc(); ifc.hpcp_event_vec = '0; ifc.cntx_inhibit = 1'b0;
    cyc(); cyc(); chk("inhibit_drop", ifc.cntx_value, 64'd0);
    ifc.hpcp_cnt_en = 1'b0;
    pulse(4);
    cyc(); ifc.hpcp_event_vec = '0; ifc.hpcp_cnt_en = 1'b1;
    cyc(); cyc(); chk("priv_drop", ifc.cntx_value, 64'd0);
    pulse(4);
    cyc(); ifc.hpcp_event_vec = '0; ifc.cntx_inhibit = 1'b1;
    cyc(); chk("inhibit_late", ifc.cntx_value, 64'd1);
    ifc.cntx_inhibit = 1'b0;

    // Asynchronous reset mid-count with a hit in flight, with ungated clock
    icg_en = 1'b1;
    ifc.cntx_wen = 1'b1;
    ifc.hpcp_wdata = 64'h1234;
    cyc(); ifc.cntx_wen = 1'b0;
    chk("rst_pre", ifc.cntx_value, 64'h1234);
    pulse(4);
    cyc(); chk("rst_inflight", ifc.cntx_value, 64'h1234);
    #2 rst = 1'b1;
    #1 chk_all("rst_async", 64'd0, 1'b0, 1'b0);
    cyc(); chk_all("rst_held", 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(); chk("rst_t1", ifc.cntx_value, 64'd0);
    cyc(); chk("rst_t2", ifc.cntx_value, 64'd1);
    ifc.hpcp_event_vec = '0;
    cyc(); chk("rst_t3", ifc.cntx_value, 64'd2);
    cyc(); chk_all("rst_t4", 64'd2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ct_hpcp_evt_cnt.md
Name: ct_hpcp_evt_cnt

Overview:
- Consumer side of the per-counter event-select register: one programmable hardware performance counter (mhpmcounterN).
- Takes the stored 6-bit event index and the vector of raw event pulses from the pipeline, and counts occurrences of the selected event.
- Supports CSR writes, inhibit and privilege filtering, and a sticky overflow flag with an interrupt pulse.
- Instantiated once per programmable counter inside the PMU, next to its event-select register.

Parameters:
- HPMCNT_NUM, 42, highest legal event index; index 0 means "no event".
- HPMEVT_WIDTH, 6, width of the event-select index.
- CNT_WIDTH, 64, counter width.

Ports:
- forever_cpuclk  in  1  ungated core clock.
- cpurst  in  1  reset, asynchronous, active-high.
- cp0_hpcp_icg_en  in  1  module-level clock-gate enable.
- pad_yy_icg_scan_en  in  1  scan enable for the gated cell.
- eventx_value  in  HPMEVT_WIDTH  selected event index.
- hpcp_event_vec  in  HPMCNT_NUM  raw event pulses; bit i-1 is event i.
- hpcp_cnt_en  in  1  privilege-mode filter; counting is allowed when 1.
- cntx_inhibit  in  1  mcountinhibit bit for this counter.
- cntx_wen  in  1  CSR write strobe.
- hpcp_wdata  in  CNT_WIDTH  CSR write data.
- cntx_of_clr  in  1  clear the sticky overflow flag.
- cntx_value  out  CNT_WIDTH  counter value.
- cntx_of  out  1  sticky overflow flag.
- cntx_of_int  out  1  one-cycle overflow interrupt pulse.

Behaviour:
- Reset (cpurst=1, asynchronous): cntx_value=0, hit_q=0, cntx_of=0, cntx_of_int=0. Reset may assert mid-operation; all state clears immediately and any in-flight hit is lost.
- sel_valid = (eventx_value != 0) && (eventx_value <= HPMCNT_NUM).
- Stage 1 (sample): hit_nxt = sel_valid & hpcp_event_vec[eventx_value-1] & hpcp_cnt_en & !cntx_inhibit. hit_q <= cntx_wen ? 0 : hit_nxt.
- The select is combinational into stage 1. A change of eventx_value applies to events sampled in that same cycle.
- Stage 2 (update), in priority order:
  - cntx_wen: cntx_value <= hpcp_wdata. The hit_q held this cycle is discarded. Events sampled in the write cycle are also discarded.
  - else if hit_q: cntx_value <= cntx_value + 1, modulo 2^CNT_WIDTH.
  - else: hold.
- Latency: an event pulse in cycle N appears in cntx_value at the edge ending cycle N+1, i.e. it is visible in cycle N+2.
- A write in cycle N is visible in cycle N+1. The first event that can count after a write is one sampled in cycle N+1.
- Wrap-around: an increment from all-ones to 0 sets cntx_of and pulses cntx_of_int for exactly one cycle, coincident with the value becoming 0. A CSR write of any value never sets cntx_of.
- cntx_of_clr clears cntx_of. If a set and a clear occur in the same cycle, the set wins.
- Inhibit or a privilege-filter drop is evaluated at sample time. An event already held in hit_q still counts even if inhibit rises in the next cycle.
- Clock gating: gated_clk_cell with clk_in=forever_cpuclk, global_en=1, external_en=0, module_en=cp0_hpcp_icg_en, local_en = cntx_wen | hit_nxt | hit_q | cntx_of_clr | cntx_of_int. All flops run on the gated clock.

Decomposition:
- Shared PMU package holds: HPMCNT_NUM, HPMEVT_WIDTH, CNT_WIDTH, the named event-index constants (e.g. EVT_L1I_ACCESS=1 ... up to 42), and an event-vector typedef.
- No new sub-module. gated_clk_cell is reused as-is.
- The event mux and counter stay in this module; the pipeline is only two stages.

Test Plan:
- Reset: cpurst pulse mid-count (value 0x1234) → all outputs 0 asynchronously; counting resumes cleanly after release.
- Basic count: eventx_value=5, event bit 4 pulsed in 3 consecutive cycles starting at N → cntx_value=1,2,3 in cycles N+2,N+3,N+4; a pulse on bit 5 alone → no change.
- Illegal and zero select: eventx_value=0 and eventx_value=43, with all event bits high for 10 cycles → cntx_value unchanged.
- Write priority: events every cycle, cntx_wen with wdata=0x100 in cycle N → value 0x100 in cycle N+1 and 0x101 in cycle N+3; the hits from cycles N-1 and N are dropped.
- Overflow: write all-ones, one event → value 0, cntx_of=1, cntx_of_int high for 1 cycle. cntx_of_clr asserted in the same cycle as a second wrap → cntx_of stays 1.
- Filters: cntx_inhibit=1 or hpcp_cnt_en=0 during pulses → no count. Inhibit rising one cycle after a pulse → that pulse still counts.
